// File: rtl/ifm_pingpong_buffer_pkg.sv
// Shared definitions for the inter-layer ping-pong feature-map store:
// bank ownership states and the map <-> (lane, slot) interleave helpers.
package ifm_pingpong_buffer_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_t;

  // Maps are interleaved across lanes: map m lives in lane m % units at slot m / units,
  // so one consumer group reads the same slot from every lane.
  function automatic int lane_map(input int group, input int lane, input int units);
    return group * units + lane;
  endfunction

  function automatic int map_lane(input int map, input int units);
    return map % units;
  endfunction

  function automatic int map_slot(input int map, input int units);
    return map / units;
  endfunction

endpackage

// File: rtl/ifm_bank_ram.sv
// One feature-map bank: IFM_DEPTH maps split over NUMBER_OF_UNITS lane RAMs,
// a single-word write port and a registered multi-lane read port.
module ifm_bank_ram
  import ifm_pingpong_buffer_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int IFM_SIZE         = 5,
  parameter int IFM_DEPTH        = 16,
  parameter int NUMBER_OF_UNITS  = 3,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int MAP_BITS         = $clog2(IFM_DEPTH),
  parameter int GROUP_BITS       = $clog2(IFM_DEPTH / NUMBER_OF_UNITS + 1)
) (
  input  logic                                  clk,
  input  logic                                  wr_enable,
  input  logic [MAP_BITS-1:0]                   wr_map,
  input  logic [ADDRESS_SIZE_IFM-1:0]           wr_address,
  input  logic [DATA_WIDTH-1:0]                 wr_data,
  input  logic                                  rd_enable,
  input  logic [GROUP_BITS-1:0]                 rd_group,
  input  logic [ADDRESS_SIZE_IFM-1:0]           rd_address,
  output logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0] rd_data
);

  localparam int WORDS      = IFM_SIZE * IFM_SIZE;
  localparam int SLOTS      = (IFM_DEPTH + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS;
  localparam int LANE_WORDS = SLOTS * WORDS;
  localparam int LANE_ABITS = $clog2(LANE_WORDS);

  int   wr_lane;
  int   wr_slot;
  logic wr_in_range;

  always_comb begin
    wr_lane     = map_lane(int'(wr_map), NUMBER_OF_UNITS);
    wr_slot     = map_slot(int'(wr_map), NUMBER_OF_UNITS);
    wr_in_range = int'(wr_address) < WORDS;
  end

  for (genvar k = 0; k < NUMBER_OF_UNITS; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] mem [LANE_WORDS];
    logic [DATA_WIDTH-1:0] lane_q;
    logic [LANE_ABITS-1:0] wr_index;
    logic [LANE_ABITS-1:0] rd_index;
    logic                  wr_hit;
    logic                  rd_ok;

    always_comb begin
      wr_index = LANE_ABITS'(wr_slot * WORDS + int'(wr_address));
      rd_index = LANE_ABITS'(int'(rd_group) * WORDS + int'(rd_address));
      wr_hit   = wr_enable && wr_in_range && (wr_lane == k);
      // Lanes past the last real map (or past the map size) read as zero.
      rd_ok    = (lane_map(int'(rd_group), k, NUMBER_OF_UNITS) < IFM_DEPTH) &&
                 (int'(rd_address) < WORDS);
    end

    // NOTE: storage and its read register carry no reset so they map onto block RAM;
    // the top level masks rd_data until a valid read. Non-blocking (<=) throughout
    // so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
      if (wr_hit) mem[wr_index] <= wr_data;
      if (rd_enable) lane_q <= rd_ok ? mem[rd_index] : '0;
    end

    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = lane_q;
  end

endmodule

// File: rtl/ifm_pingpong_buffer.sv
// Double-banked feature-map store between two conv layers: producer fills one bank
// while the consumer drains the other; per-bank FSMs track ownership.
module ifm_pingpong_buffer
  import ifm_pingpong_buffer_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int IFM_SIZE         = 5,
  parameter int IFM_DEPTH        = 16,
  parameter int NUMBER_OF_UNITS  = 3,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int GROUP_BITS       = $clog2(IFM_DEPTH / NUMBER_OF_UNITS + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  wr_enable,
  input  logic [$clog2(IFM_DEPTH)-1:0]          wr_map,
  input  logic [ADDRESS_SIZE_IFM-1:0]           wr_address,
  input  logic [DATA_WIDTH-1:0]                 wr_data,
  input  logic                                  wr_done,
  output logic                                  producer_ready,
  input  logic                                  rd_enable,
  input  logic [GROUP_BITS-1:0]                 rd_group,
  input  logic [ADDRESS_SIZE_IFM-1:0]           rd_address,
  output logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0] rd_data,
  input  logic                                  rd_done,
  output logic                                  start_to_consumer,
  output logic                                  ifm_sel_consumer,
  output logic                                  overflow_error
);

  localparam int MAP_BITS = $clog2(IFM_DEPTH);
  localparam int RD_WIDTH = NUMBER_OF_UNITS * DATA_WIDTH;

  bank_state_t          state_q    [2];
  bank_state_t          state_next [2];
  logic                 wr_ptr, wr_ptr_next;
  logic                 rd_ptr, rd_ptr_next;
  logic                 wr_accept, done_accept, start_fire, rd_release;
  logic                 drain_active, any_draining, ready_next;
  logic                 rd_zero_q, rd_bank_q;
  logic [1:0]           bank_we;
  logic [RD_WIDTH-1:0]  bank_rd_data [2];

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_next[0] = state_q[0];
    state_next[1] = state_q[1];
    wr_ptr_next   = wr_ptr;
    rd_ptr_next   = rd_ptr;
    wr_accept     = wr_enable && producer_ready;
    done_accept   = wr_done && producer_ready;
    drain_active  = state_q[rd_ptr] == BANK_DRAINING;
    any_draining  = (state_q[0] == BANK_DRAINING) || (state_q[1] == BANK_DRAINING);
    start_fire    = (state_q[rd_ptr] == BANK_FULL) && !any_draining;
    rd_release    = rd_done && drain_active;

    if (wr_accept && state_q[wr_ptr] == BANK_EMPTY) state_next[wr_ptr] = BANK_FILLING;
    if (done_accept) begin
      state_next[wr_ptr] = BANK_FULL;
      wr_ptr_next        = !wr_ptr;
    end
    if (start_fire) state_next[rd_ptr] = BANK_DRAINING;
    // Fill and drain always own different banks, so both pulses can land together.
    if (rd_release) begin
      state_next[rd_ptr] = BANK_EMPTY;
      rd_ptr_next        = !rd_ptr;
    end

    ready_next = (state_next[wr_ptr_next] == BANK_EMPTY) ||
                 (state_next[wr_ptr_next] == BANK_FILLING);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q[0]        <= BANK_EMPTY;
      state_q[1]        <= BANK_EMPTY;
      wr_ptr            <= 1'b0;
      rd_ptr            <= 1'b0;
      producer_ready    <= 1'b1;
      start_to_consumer <= 1'b0;
      ifm_sel_consumer  <= 1'b0;
      overflow_error    <= 1'b0;
      rd_zero_q         <= 1'b1;
      rd_bank_q         <= 1'b0;
    end else begin
      state_q[0]        <= state_next[0];
      state_q[1]        <= state_next[1];
      wr_ptr            <= wr_ptr_next;
      rd_ptr            <= rd_ptr_next;
      producer_ready    <= ready_next;
      start_to_consumer <= start_fire;
      if (start_fire) ifm_sel_consumer <= rd_ptr;
      if ((wr_enable || wr_done) && !producer_ready) overflow_error <= 1'b1;
      if (rd_enable) begin
        rd_bank_q <= rd_ptr;
        rd_zero_q <= !drain_active;
      end
    end
  end

  assign bank_we[0] = wr_accept && !wr_ptr;
  assign bank_we[1] = wr_accept && wr_ptr;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ifm_bank_ram #(
      .DATA_WIDTH      (DATA_WIDTH),
      .IFM_SIZE        (IFM_SIZE),
      .IFM_DEPTH       (IFM_DEPTH),
      .NUMBER_OF_UNITS (NUMBER_OF_UNITS),
      .ADDRESS_SIZE_IFM(ADDRESS_SIZE_IFM),
      .MAP_BITS        (MAP_BITS),
      .GROUP_BITS      (GROUP_BITS)
    ) u_ram (
      .clk       (clk),
      .wr_enable (bank_we[b]),
      .wr_map    (wr_map),
      .wr_address(wr_address),
      .wr_data   (wr_data),
      .rd_enable (rd_enable),
      .rd_group  (rd_group),
      .rd_address(rd_address),
      .rd_data   (bank_rd_data[b])
    );
  end

  // Both banks read every time; the registered bank select and zero flag pick the result.
  assign rd_data = rd_zero_q ? '0 : bank_rd_data[rd_bank_q];

endmodule

// File: tb/tb_ifm_pingpong_buffer.sv
// Scoreboard bench for ifm_pingpong_buffer: stimulus pushes expected read data and
// start-pulse bank indices; a monitor pops and compares whenever the DUT responds.
module tb_ifm_pingpong_buffer;

  localparam int DW = 32;
  localparam int RW = 3 * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_enable, wr_done, rd_enable, rd_done;
  logic [3:0]    wr_map;
  logic [4:0]    wr_address, rd_address;
  logic [DW-1:0] wr_data;
  logic [2:0]    rd_group;
  logic          producer_ready, start_to_consumer, ifm_sel_consumer, overflow_error;
  logic [RW-1:0] rd_data;

  int passed = 0;
  int total  = 0;

  logic [RW-1:0] sb_rd[$];
  logic          sb_start[$];

  ifm_pingpong_buffer dut (
    .clk              (clk),
    .reset            (reset),
    .wr_enable        (wr_enable),
    .wr_map           (wr_map),
    .wr_address       (wr_address),
    .wr_data          (wr_data),
    .wr_done          (wr_done),
    .producer_ready   (producer_ready),
    .rd_enable        (rd_enable),
    .rd_group         (rd_group),
    .rd_address       (rd_address),
    .rd_data          (rd_data),
    .rd_done          (rd_done),
    .start_to_consumer(start_to_consumer),
    .ifm_sel_consumer (ifm_sel_consumer),
    .overflow_error   (overflow_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input logic [3:0] map, input logic [4:0] addr, input logic [DW-1:0] data);
    wr_enable = 1'b1; wr_map = map; wr_address = addr; wr_data = data;
    @(negedge clk);
    wr_enable = 1'b0;
  endtask

  task automatic pulse(input logic do_wr_done, input logic do_rd_done);
    wr_done = do_wr_done; rd_done = do_rd_done;
    @(negedge clk);
    wr_done = 1'b0; rd_done = 1'b0;
  endtask

  task automatic read(input logic [2:0] group, input logic [4:0] addr, input logic [RW-1:0] exp);
    rd_enable = 1'b1; rd_group = group; rd_address = addr;
    sb_rd.push_back(exp);
    @(negedge clk);
    rd_enable = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, RW'(producer_ready), RW'(1));
    check({tag, "_overflow"}, RW'(overflow_error), RW'(0));
    check({tag, "_start"}, RW'(start_to_consumer), RW'(0));
    check({tag, "_sel"}, RW'(ifm_sel_consumer), RW'(0));
    check({tag, "_rd_data"}, rd_data, '0);
  endtask

  initial begin : monitor
    logic fired;
    forever begin
      @(posedge clk);
      fired = rd_enable;
      #1;
      if (fired && sb_rd.size() > 0) check("rd_data", rd_data, sb_rd.pop_front());
      if (start_to_consumer === 1'b1) begin
        if (sb_start.size() > 0) check("start_sel", RW'(ifm_sel_consumer), RW'(sb_start.pop_front()));
        else check("start_unexpected", RW'(start_to_consumer), RW'(0));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    reset = 1'b0;
    wr_enable = 1'b0; wr_done = 1'b0; rd_enable = 1'b0; rd_done = 1'b0;
    wr_map = '0; wr_address = '0; wr_data = '0; rd_group = '0; rd_address = '0;
    idle(2);
    check_reset_outputs("reset");
    reset = 1'b1;

    // Fill bank 0: maps 3/4/5 at addr 7, map 15 at addr 0.
    write(4'd3, 5'd7, 32'hA5A5_A5A5);
    write(4'd4, 5'd7, 32'h4444_0004);
    write(4'd5, 5'd7, 32'h5555_0005);
    write(4'd15, 5'd0, 32'h0000_0011);
    sb_start.push_back(1'b0);
    pulse(1'b1, 1'b0);
    idle(2);
    check("ready_bank1_free", RW'(producer_ready), RW'(1));
    read(3'd1, 5'd7, {32'h5555_0005, 32'h4444_0004, 32'hA5A5_A5A5});
    read(3'd5, 5'd0, {32'h0, 32'h0, 32'h0000_0011});
    idle(2);
    check("rd_hold", rd_data, {32'h0, 32'h0, 32'h0000_0011});

    // Fill bank 1, then wr_done (bank 1) and rd_done (bank 0) in the same cycle.
    write(4'd0, 5'd1, 32'h0000_00B1);
    write(4'd1, 5'd1, 32'h0000_00B2);
    write(4'd2, 5'd1, 32'h0000_00B3);
    sb_start.push_back(1'b1);
    pulse(1'b1, 1'b1);
    idle(1);
    check("simul_start", RW'(start_to_consumer), RW'(1));
    check("simul_sel", RW'(ifm_sel_consumer), RW'(1));
    check("simul_no_overflow", RW'(overflow_error), RW'(0));
    check("simul_ready", RW'(producer_ready), RW'(1));
    read(3'd0, 5'd1, {32'h0000_00B3, 32'h0000_00B2, 32'h0000_00B1});

    // Fill bank 0 while bank 1 still drains: both banks busy.
    write(4'd6, 5'd2, 32'h0000_00C6);
    write(4'd7, 5'd2, 32'h0000_00C7);
    write(4'd8, 5'd2, 32'h0000_00C8);
    pulse(1'b1, 1'b0);
    check("full_not_ready", RW'(producer_ready), RW'(0));
    write(4'd0, 5'd1, 32'hDEAD_BEEF);
    check("overflow_set", RW'(overflow_error), RW'(1));
    read(3'd0, 5'd1, {32'h0000_00B3, 32'h0000_00B2, 32'h0000_00B1});
    sb_start.push_back(1'b0);
    pulse(1'b0, 1'b1);
    check("ready_after_release", RW'(producer_ready), RW'(1));
    idle(2);
    read(3'd2, 5'd2, {32'h0000_00C8, 32'h0000_00C7, 32'h0000_00C6});

    // Reset while bank 0 drains.
    reset = 1'b0;
    idle(2);
    check_reset_outputs("midreset");
    reset = 1'b1;
    idle(4);
    read(3'd2, 5'd2, '0);
    check("post_reset_ready", RW'(producer_ready), RW'(1));

    // Handoff with zero writes; memory survived the reset.
    sb_start.push_back(1'b0);
    pulse(1'b1, 1'b0);
    idle(3);
    check("empty_handoff_ready", RW'(producer_ready), RW'(1));
    read(3'd2, 5'd2, {32'h0000_00C8, 32'h0000_00C7, 32'h0000_00C6});

    idle(3);
    check("rd_queue_drained", RW'(sb_rd.size()), RW'(0));
    check("start_queue_drained", RW'(sb_start.size()), RW'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
